// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// master: byte source; slave: loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: takes a 16-bit little-endian word count followed by the
// payload bytes, assembles little-endian 32-bit words, writes them to instruction
// memory and releases cpu_hold once the image is complete.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_loader_if.slave          in_if,
    input  logic                  reload,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        StLen0,
        StLen1,
        StData,
`ifdef LOADER_CHECKSUM_EN
        StCsum,
`endif
        StDone,
        StErr
    } state_e;

    localparam logic [15:0] MaxLen = 16'(MAX_WORDS);

    // Where the image goes once the payload is complete, and whether it still takes bytes.
`ifdef LOADER_CHECKSUM_EN
    localparam state_e FinalSt    = StCsum;
    localparam logic   FinalReady = 1'b1;
`else
    localparam state_e FinalSt    = StDone;
    localparam logic   FinalReady = 1'b0;
`endif

    state_e                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic        accept;
    logic [15:0] len_new;

    assign accept  = in_if.in_valid && in_ready_q;
    assign len_new = {in_if.in_data, len_q[7:0]};

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            StLen0: begin
                if (accept) begin
                    len_d[7:0] = in_if.in_data;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    len_d      = len_new;
                    byte_cnt_d = 2'd0;
                    word_idx_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                    if (len_new == 16'd0) begin
                        state_d    = FinalSt;
                        in_ready_d = FinalReady;
                    end else if (len_new > MaxLen) begin
                        state_d    = StErr;
                        in_ready_d = 1'b0;
                        error_d    = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    wr_data_d[{byte_cnt_q, 3'b000} +: 8] = in_if.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_if.in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = ADDR_WIDTH'(word_idx_q);
                        word_idx_d = word_idx_q + 16'd1;
                        if (word_idx_q + 16'd1 == len_q) begin
                            state_d    = FinalSt;
                            in_ready_d = FinalReady;
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    in_ready_d = 1'b0;
                    if (in_if.in_data == csum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            StDone, StErr: begin
                if (reload) begin
                    state_d    = StLen0;
                    in_ready_d = 1'b1;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    word_idx_d = 16'd0;
                    byte_cnt_d = 2'd0;
                end else if (state_q == StDone) begin
                    // Release lands the cycle after entry, i.e. after the final write strobe.
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
            end
            default: begin
                state_d    = StErr;
                in_ready_d = 1'b0;
                error_d    = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StLen0;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            word_idx_q <= 16'd0;
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = word_idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as each image is
// streamed, and a negedge monitor pops and compares every write strobe.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        reload;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader_if in_if ();

    imem_loader #(
        .ADDR_WIDTH (10),
        .MAX_WORDS  (1024)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_if        (in_if),
        .reload       (reload),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] stim[$];
    int         checks = 0;
    int         errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write",
                         wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic rdy, input logic hold,
                                input logic dn, input logic err, input logic [15:0] words);
        check({name, ".in_ready"}, 32'(in_if.in_ready), 32'(rdy));
        check({name, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
        check({name, ".done"}, 32'(done), 32'(dn));
        check({name, ".error"}, 32'(error), 32'(err));
        check({name, ".words_loaded"}, 32'(words_loaded), 32'(words));
    endtask

    function automatic void expect_wr(input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endfunction

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int n;
        in_if.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_if.in_valid = 1'b1;
        in_if.in_data  = b;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            if (in_if.in_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_stim(input string name, input bit gapped);
        bit ok;
        foreach (stim[i]) begin
            send_byte(stim[i], gapped ? int'($urandom_range(1, 3)) : 0, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL %s.accept: byte %0d not accepted, required accepted", name, i);
            end
        end
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got no done/error, required one within 100 cycles", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        bit ok;
        reset          = 1'b0;
        reload         = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_status("reset", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        check("reset.wr_en", 32'(wr_en), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Two-word image, continuous stream.
        expect_wr(10'd0, 32'h00A00513);
        expect_wr(10'd1, 32'h0000006F);
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'hD9);
`endif
        send_stim("two_word", 1'b0);
        wait_end("two_word");
        check_status("two_word", 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        check("two_word.drained", 32'(sb.size()), 32'd0);

        // Same image with random gaps between bytes.
        pulse_reload();
        check_status("reload1", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        expect_wr(10'd0, 32'h00A00513);
        expect_wr(10'd1, 32'h0000006F);
        send_stim("gapped", 1'b1);
        wait_end("gapped");
        check_status("gapped", 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        check("gapped.drained", 32'(sb.size()), 32'd0);

        // Empty image.
        pulse_reload();
        stim = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h00);
`endif
        send_stim("n0", 1'b0);
        wait_end("n0");
        check_status("n0", 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);

        // Oversized image (1025 words).
        pulse_reload();
        stim = '{8'h01, 8'h04};
        send_stim("n1025", 1'b0);
        wait_end("n1025");
        check_status("n1025", 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
        send_byte(8'h55, 0, ok);
        in_if.in_valid = 1'b0;
        check("n1025.no_accept", 32'(ok), 32'd0);
        check("n1025.error_sticky", 32'(error), 32'd1);

        // Reset after 1.5 words of a 4-word image.
        pulse_reload();
        expect_wr(10'd0, 32'h04030201);
        stim = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_stim("partial", 1'b0);
        #2 reset = 1'b0;
        #1;
        check_status("midreset", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        check("midreset.wr_en", 32'(wr_en), 32'd0);
        check("midreset.wr_addr", 32'(wr_addr), 32'd0);
        check("midreset.wr_data", wr_data, 32'd0);
        check("midreset.drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // One-word image, then reload and a new image from address 0.
        expect_wr(10'd0, 32'h12345678);
        stim = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h08);
`endif
        send_stim("one_word", 1'b0);
        wait_end("one_word");
        check_status("one_word", 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
        pulse_reload();
        check_status("reload2", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        expect_wr(10'd0, 32'hDEADBEEF);
        expect_wr(10'd1, 32'h0BADF00D);
        stim = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h79);
`endif
        send_stim("reloaded", 1'b0);
        wait_end("reloaded");
        check_status("reloaded", 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        check("reloaded.drained", 32'(sb.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        pulse_reload();
        expect_wr(10'd0, 32'h44332211);
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_stim("csum_ok", 1'b0);
        wait_end("csum_ok");
        check_status("csum_ok", 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
        pulse_reload();
        expect_wr(10'd0, 32'h44332211);
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_stim("csum_bad", 1'b0);
        wait_end("csum_bad");
        check_status("csum_bad", 1'b0, 1'b1, 1'b0, 1'b1, 16'd1);
        check("csum_bad.drained", 32'(sb.size()), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the single-cycle RISC-V core.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory through a write port.
- Holds the core in reset (cpu_hold) until the whole image is written, then releases it.

Parameters:
- ADDR_WIDTH, 10, width of word address driven to instruction memory.
- MAX_WORDS, 1024, largest accepted image in words; must be <= 2**ADDR_WIDTH and <= 65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle request to restart loading; honoured only in DONE or ERR.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  ADDR_WIDTH  word index of the write (byte address = wr_addr*4).
- wr_data  output  32  assembled word.
- cpu_hold  output  1  high keeps the core in reset.
- done  output  1  image loaded successfully.
- error  output  1  image rejected; sticky until reload or reset.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- A byte is accepted on a rising edge when in_valid && in_ready. All outputs are registered.
- States: LEN0, LEN1, DATA, (CSUM), DONE, ERR.
- Reset (async, reset==0) values:
  - state=LEN0, in_ready=1, wr_en=0, wr_addr=0, wr_data=0.
  - cpu_hold=1, done=0, error=0, words_loaded=0.
  - Byte counter=0, length register=0.
- Reset asserted mid-load aborts immediately to these values. No partial write strobe is issued after reset asserts.
- LEN0: the accepted byte becomes N[7:0]; go to LEN1.
- LEN1: the accepted byte becomes N[15:8]. Then:
  - N==0 -> DONE (or CSUM if the option is enabled).
  - N>MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA: bytes fill wr_data LSB first (byte0 -> [7:0] ... byte3 -> [31:24]).
  - On the edge accepting byte3, wr_en=1 for the next cycle, with wr_addr = current word index and wr_data = the full word.
  - The word index and words_loaded increment on that same edge.
  - in_ready stays 1 during the wr_en cycle (no bubble), so back-to-back bytes continue without stall.
  - After word N-1 is accepted -> DONE (or CSUM).
  - Gaps in in_valid are allowed anywhere; partial-word state is held across them.
- DONE:
  - in_ready=0, done=1, cpu_hold=0. cpu_hold deasserts the cycle after entry, i.e. the cycle after the final wr_en is seen.
- ERR:
  - in_ready=0, error=1, cpu_hold=1. No further writes.
- reload in DONE/ERR:
  - Go to LEN0; cpu_hold=1, done=0, error=0, words_loaded=0, word index=0.
  - Memory contents are not cleared.
  - reload in any other state is ignored.
- words_loaded wraps never: it is bounded by MAX_WORDS.
- wr_addr is the word index truncated to ADDR_WIDTH.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload word (or after LEN1 when N==0), enter CSUM with in_ready=1.
  - The next accepted byte is compared to the XOR of all payload bytes; the length bytes are excluded, and the running XOR is 0 when N==0.
  - Match -> DONE. Mismatch -> ERR.
  - Words already written stay written, but cpu_hold remains 1.
- Not defined:
  - CSUM state and the XOR register do not exist; transitions go straight to DONE.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> cpu_hold=1, in_ready=1, wr_en=0, done=0, error=0, words_loaded=0.
- Two-word load:
  - Stream 02 00 | 13 05 A0 00 | 6F 00 00 00, in_valid continuous.
  - Expect wr_en@addr0 = 0x00A00513 and wr_en@addr1 = 0x0000006F, one cycle each.
  - Then done=1, cpu_hold=0, words_loaded=2, in_ready=0.
- Gapped input: same stream with in_valid low for 1-3 random cycles between bytes -> identical writes and final state.
- Length boundaries:
  - N=0 (00 00) -> DONE with no wr_en.
  - N=1025 (01 04) with MAX_WORDS=1024 -> error=1, cpu_hold=1, no wr_en, further bytes not accepted.
- Reset and reload:
  - Assert reset after 1.5 words of a 4-word load -> all outputs at reset values with no stray wr_en.
  - Then reload from DONE -> cpu_hold=1, new image written from addr 0.
- LOADER_CHECKSUM_EN:
  - Stream 01 00 11 22 33 44 44 -> DONE (11^22^33^44=0x44).
  - Final byte 45 instead -> error=1, cpu_hold=1, wr_en seen once at addr0.
